fifo_stim_driver: RTL and testbench

//  Synthesizable stimulus driver for the FIFO interface: the driving end facing the FIFO monitor/checker.

---
 rtl/fifo_stim_pkg.sv | 29 ++
 rtl/fifo_lfsr16.sv | 28 ++
 rtl/fifo_stim_driver.sv | 180 ++++++++++++++++++
 tb/tb_fifo_stim_driver.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stim_pkg.sv
// Shared types and constants for the FIFO stimulus driver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_stim_pkg;

    typedef enum logic [1:0] {
        WR_ONLY    = 2'd0,
        RD_ONLY    = 2'd1,
        MIXED      = 2'd2,
        FILL_DRAIN = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RESET_DUT = 2'd1,
        RUN       = 2'd2,
        DONE      = 2'd3
    } state_e;

    localparam logic [15:0] LFSR_TAPS        = 16'hB400;
    localparam logic [15:0] LFSR_CTL_DEFAULT = 16'hACE1;
    localparam logic [15:0] LFSR_DAT_DEFAULT = 16'h531E;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
    endfunction

endpackage

// File: rtl/fifo_lfsr16.sv
// 16-bit Galois LFSR with synchronous load and step enable.
// Latency: q updates one cycle after load/step.
// Backpressure: none; steps whenever step is high. A zero seed loads RESET_VAL so q never locks at 0.
module fifo_lfsr16
    import fifo_stim_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = LFSR_CTL_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] q
);

    // Load has priority over step; a zero seed falls back to the default state.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= (seed == 16'h0) ? RESET_VAL : seed;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/fifo_stim_driver.sv
// LFSR-driven FIFO stimulus generator: DUT reset phase, then one transaction per cycle.
// Latency: all outputs registered, one cycle after the deciding edge.
// Backpressure: none; full/empty only steer the FILL_DRAIN phase, overflow/underflow is deliberate.
module fifo_stim_driver
    import fifo_stim_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int WR_THR     = 179,
    parameter int RD_THR     = 77,
    parameter int RST_THR    = 3,
    parameter int RST_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [15:0]           num_txn,
    input  logic [15:0]           seed,
    input  logic                  full,
    input  logic                  empty,
    output logic [FIFO_WIDTH-1:0] data_in,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic                  fifo_rst_n,
    output logic                  test_trigger,
    output logic                  test_finish,
    output logic                  busy,
    output logic [15:0]           txn_count
);

    // Thresholds widened to 9 bits so a threshold of 256 means "always".
    localparam logic [8:0] WR_LIM   = 9'(WR_THR);
    localparam logic [8:0] RD_LIM   = 9'(RD_THR);
    localparam logic [8:0] RST_LIM  = 9'(RST_THR);
    localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);

    state_e                  state_q, state_d;
    mode_e                   mode_q, mode_d;
    logic [15:0]             num_q, num_d;
    logic [7:0]              rcnt_q, rcnt_d;
    logic                    drain_q, drain_d;
    logic                    drain_eff;
    logic [FIFO_WIDTH-1:0]   data_d;
    logic                    wr_d, rd_d, frst_d, trig_d, fin_d, busy_d;
    logic [15:0]             txn_d, txn_inc;
    logic [15:0]             eff_seed, ctl_q, dat_q;
    logic [7:0]              mix_xor;
    logic                    lfsr_load, lfsr_step;

    assign eff_seed  = (seed == 16'h0) ? LFSR_CTL_DEFAULT : seed;
    assign txn_inc   = (txn_count == 16'hFFFF) ? txn_count : txn_count + 16'd1;
    assign mix_xor   = ctl_q[7:0] ^ ctl_q[15:8];
    // FILL flips to DRAIN on full, DRAIN flips back to FILL on empty.
    assign drain_eff = drain_q ? !empty : full;

    fifo_lfsr16 #(.RESET_VAL(LFSR_CTL_DEFAULT)) u_ctl_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .seed (eff_seed),
        .step (lfsr_step),
        .q    (ctl_q)
    );

    fifo_lfsr16 #(.RESET_VAL(LFSR_DAT_DEFAULT)) u_dat_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .seed (~eff_seed),
        .step (lfsr_step),
        .q    (dat_q)
    );

    // Next-state and next-output decode; outputs default to idle values.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        num_d     = num_q;
        rcnt_d    = rcnt_q;
        drain_d   = drain_q;
        data_d    = data_in;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        frst_d    = 1'b1;
        trig_d    = 1'b0;
        fin_d     = 1'b0;
        busy_d    = 1'b0;
        txn_d     = txn_count;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RESET_DUT;
                    mode_d    = mode_e'(mode);
                    num_d     = num_txn;
                    rcnt_d    = 8'd0;
                    drain_d   = 1'b0;
                    txn_d     = 16'd0;
                    frst_d    = 1'b0;
                    busy_d    = 1'b1;
                    lfsr_load = 1'b1;
                end
            end
            RESET_DUT: begin
                frst_d = 1'b0;
                busy_d = 1'b1;
                if (rcnt_q == RST_LAST) begin
                    frst_d  = 1'b1;
                    state_d = (num_q == 16'd0) ? DONE : RUN;
                    busy_d  = (num_q != 16'd0);
                end else begin
                    rcnt_d = rcnt_q + 8'd1;
                end
            end
            RUN: begin
                busy_d    = 1'b1;
                trig_d    = 1'b1;
                lfsr_step = 1'b1;
                data_d    = dat_q[FIFO_WIDTH-1:0];
                txn_d     = txn_inc;
                case (mode_q)
                    WR_ONLY: wr_d = 1'b1;
                    RD_ONLY: rd_d = 1'b1;
                    MIXED: begin
                        wr_d   = {1'b0, ctl_q[7:0]} < WR_LIM;
                        rd_d   = {1'b0, ctl_q[15:8]} < RD_LIM;
                        frst_d = !({1'b0, mix_xor} < RST_LIM);
                    end
                    FILL_DRAIN: begin
                        drain_d = drain_eff;
                        wr_d    = !drain_eff;
                        rd_d    = drain_eff;
                    end
                    default: ;
                endcase
                // busy stays high with the finishing transaction and drops the cycle after.
                if (txn_inc == num_q) begin
                    fin_d   = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mode_q       <= WR_ONLY;
            num_q        <= 16'd0;
            rcnt_q       <= 8'd0;
            drain_q      <= 1'b0;
            data_in      <= '0;
            wr_en        <= 1'b0;
            rd_en        <= 1'b0;
            fifo_rst_n   <= 1'b1;
            test_trigger <= 1'b0;
            test_finish  <= 1'b0;
            busy         <= 1'b0;
            txn_count    <= 16'd0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            num_q        <= num_d;
            rcnt_q       <= rcnt_d;
            drain_q      <= drain_d;
            data_in      <= data_d;
            wr_en        <= wr_d;
            rd_en        <= rd_d;
            fifo_rst_n   <= frst_d;
            test_trigger <= trig_d;
            test_finish  <= fin_d;
            busy         <= busy_d;
            txn_count    <= txn_d;
        end
    end

endmodule

// File: tb/tb_fifo_stim_driver.sv
// Bench for fifo_stim_driver: table of runs checked through a transaction scoreboard,
// plus hand sequences for mid-run reset and a forced-threshold MIXED instance.
// A depth-8 FIFO occupancy model supplies full/empty to the main instance.
module tb_fifo_stim_driver;
    import fifo_stim_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, full, empty;
    logic [1:0]  mode;
    logic [15:0] num_txn, seed;
    logic [15:0] data_in, txn_count;
    logic        wr_en, rd_en, fifo_rst_n, test_trigger, test_finish, busy;

    logic        mx_start, mx_full, mx_empty;
    logic [1:0]  mx_mode;
    logic [15:0] mx_num, mx_seed;
    logic [15:0] mx_data, mx_count;
    logic        mx_wr, mx_rd, mx_frst, mx_trig, mx_fin, mx_busy;

    fifo_stim_driver u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .num_txn(num_txn), .seed(seed),
        .full(full), .empty(empty), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .fifo_rst_n(fifo_rst_n), .test_trigger(test_trigger), .test_finish(test_finish),
        .busy(busy), .txn_count(txn_count)
    );

    fifo_stim_driver #(.WR_THR(256), .RD_THR(0), .RST_THR(0)) u_mx (
        .clk(clk), .rst(rst), .start(mx_start), .mode(mx_mode), .num_txn(mx_num), .seed(mx_seed),
        .full(mx_full), .empty(mx_empty), .data_in(mx_data), .wr_en(mx_wr), .rd_en(mx_rd),
        .fifo_rst_n(mx_frst), .test_trigger(mx_trig), .test_finish(mx_fin),
        .busy(mx_busy), .txn_count(mx_count)
    );

    // FIFO occupancy model: overflow writes and underflow reads are dropped.
    int fcnt = 0;
    always @(posedge clk) begin
        if (rst || !fifo_rst_n) fcnt <= 0;
        else if (wr_en && !rd_en && fcnt < DEPTH) fcnt <= fcnt + 1;
        else if (rd_en && !wr_en && fcnt > 0) fcnt <= fcnt - 1;
    end
    assign full  = (fcnt == DEPTH);
    assign empty = (fcnt == 0);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic        rstn;
        logic        fin;
        logic [15:0] data;
        logic [15:0] cnt;
    } txn_t;

    txn_t sb_q[$];
    logic sb_on = 1'b0;
    int   trig_cnt, fin_cnt;

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        logic        fb;
        logic [15:0] n;
        fb = s[0];
        n = {fb, s[15:1]};
        n[13] ^= fb;
        n[12] ^= fb;
        n[10] ^= fb;
        return n;
    endfunction

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] num;
        logic [15:0] seed;
        bit          poke;
        int          exp_trig;
        int          exp_rlow;
    } vec_t;

    // Expected transaction stream for one run.
    // FILL_DRAIN against the depth-8 model: full is seen at txn 10, empty at txn 19,
    // so txns 1-9 write, 10-18 read, 19+ write again.
    task automatic build_expected(input vec_t v);
        logic [15:0] ctl, dat, eff;
        txn_t        t;
        eff = (v.seed == 16'h0) ? 16'hACE1 : v.seed;
        ctl = eff;
        dat = ~eff;
        if (dat == 16'h0) dat = 16'h531E;
        for (int i = 0; i < int'(v.num); i++) begin
            t.data = dat;
            t.cnt  = 16'(i + 1);
            t.fin  = (i == int'(v.num) - 1);
            t.rstn = 1'b1;
            case (v.mode)
                2'd0: begin t.wr = 1'b1; t.rd = 1'b0; end
                2'd1: begin t.wr = 1'b0; t.rd = 1'b1; end
                2'd2: begin
                    t.wr   = int'(ctl[7:0]) < 179;
                    t.rd   = int'(ctl[15:8]) < 77;
                    t.rstn = !(int'(ctl[7:0] ^ ctl[15:8]) < 3);
                end
                default: begin
                    t.wr = (i < 9) || (i >= 18);
                    t.rd = !t.wr;
                end
            endcase
            sb_q.push_back(t);
            ctl = ref_step(ctl);
            dat = ref_step(dat);
        end
    endtask

    // Scoreboard: each trigger pops one expected transaction.
    always @(negedge clk) begin
        if (sb_on && test_trigger) begin
            trig_cnt++;
            if (test_finish) fin_cnt++;
            if (sb_q.size() == 0) begin
                check("sb_unexpected_trigger", 64'(test_trigger), 64'd0);
            end else begin
                check("sb_txn", 64'({wr_en, rd_en, fifo_rst_n, test_finish, data_in, txn_count}),
                      64'(sb_q.pop_front()));
                if (test_finish) check("busy_with_finish", 64'(busy), 64'd1);
            end
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        int rlow;
        bit done, poked;
        rlow = 0; done = 1'b0; poked = 1'b0;
        sb_q.delete();
        build_expected(v);
        trig_cnt = 0;
        fin_cnt  = 0;
        sb_on    = 1'b1;
        @(negedge clk);
        mode = v.mode; num_txn = v.num; seed = v.seed; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble run inputs: the driver must use the values latched at start.
        mode = v.mode + 2'd1; num_txn = v.num + 16'd5; seed = ~v.seed;
        check($sformatf("v%0d_busy_after_start", idx), 64'(busy), 64'd1);
        for (int c = 0; c < 400; c++) begin
            if (!fifo_rst_n && !test_trigger) rlow++;
            if (!busy) begin done = 1'b1; break; end
            if (v.poke && !poked && trig_cnt >= 3) begin
                start = 1'b1; mode = 2'd0; poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        sb_on = 1'b0;
        check($sformatf("v%0d_run_completed", idx), 64'(done), 64'd1);
        check($sformatf("v%0d_trigger_count", idx), 64'(trig_cnt), 64'(v.exp_trig));
        check($sformatf("v%0d_rst_low_cycles", idx), 64'(rlow), 64'(v.exp_rlow));
        check($sformatf("v%0d_txn_count_final", idx), 64'(txn_count), 64'(v.num));
        check($sformatf("v%0d_finish_pulses", idx), 64'(fin_cnt), (v.num != 0) ? 64'd1 : 64'd0);
        check($sformatf("v%0d_scoreboard_left", idx), 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs[7];

    initial begin
        bit found;
        int mx_trigs;
        bit mx_done;

        vecs[0] = '{2'd0, 16'd10, 16'h0000, 1'b0, 10, 2};
        vecs[1] = '{2'd1, 16'd7,  16'h1234, 1'b1, 7,  2};
        vecs[2] = '{2'd2, 16'd60, 16'hBEEF, 1'b0, 60, 2};
        vecs[3] = '{2'd0, 16'd3,  16'hFFFF, 1'b0, 3,  2};
        vecs[4] = '{2'd2, 16'd0,  16'h0005, 1'b0, 0,  2};
        vecs[5] = '{2'd3, 16'd20, 16'h0F0F, 1'b0, 20, 2};
        vecs[6] = '{2'd1, 16'd1,  16'h0001, 1'b0, 1,  2};

        rst = 1'b1; start = 1'b0; mode = 2'd0; num_txn = 16'd0; seed = 16'd0;
        mx_start = 1'b0; mx_mode = 2'd2; mx_num = 16'd0; mx_seed = 16'd0;
        mx_full = 1'b0; mx_empty = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_data_in", 64'(data_in), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_fifo_rst_n", 64'(fifo_rst_n), 64'd1);
        check("rst_trigger", 64'(test_trigger), 64'd0);
        check("rst_finish", 64'(test_finish), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_txn_count", 64'(txn_count), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Synchronous reset in the middle of a run.
        @(negedge clk);
        mode = 2'd0; num_txn = 16'd20; seed = 16'h2222; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (txn_count == 16'd5) begin found = 1'b1; break; end
            @(negedge clk);
        end
        check("midrun_reached_txn5", 64'(found), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_state_idle", 64'(u_dut.state_q), 64'(IDLE));
        check("midrun_txn_count", 64'(txn_count), 64'd0);
        check("midrun_outputs", 64'({data_in, wr_en, rd_en, fifo_rst_n, test_trigger, test_finish, busy}),
              64'({16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrun_stays_idle", 64'({test_trigger, busy}), 64'd0);

        // Forced thresholds: always write, never read, never inject a DUT reset.
        mx_num = 16'd25; mx_seed = 16'h5A5A; mx_start = 1'b1;
        @(negedge clk);
        mx_start = 1'b0;
        mx_trigs = 0;
        mx_done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (mx_trig) begin
                mx_trigs++;
                check("mx_enables", 64'({mx_wr, mx_rd, mx_frst}), 64'(3'b101));
            end
            if (!mx_busy) begin mx_done = 1'b1; break; end
            @(negedge clk);
        end
        check("mx_run_completed", 64'(mx_done), 64'd1);
        check("mx_trigger_count", 64'(mx_trigs), 64'd25);
        check("mx_txn_count", 64'(mx_count), 64'd25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
